// File: rtl/ipml_sync_prefetch_fifo_v2_0_if.sv
// Write/read handshake bundle for the prefetch FIFO.
// master: producer/consumer side, slave: FIFO side.
interface ipml_sync_prefetch_fifo_v2_0_if #(
    parameter int c_DEPTH_WIDTH = 4,
    parameter int c_DATA_WIDTH  = 32
);
    logic                    flush;
    logic [c_DATA_WIDTH-1:0] wr_data;
    logic                    wr_en;
    logic                    wr_vld;
    logic [c_DATA_WIDTH-1:0] rd_data;
    logic                    rd_en;
    logic                    rd_vld;
    logic [c_DEPTH_WIDTH:0]  level;
    logic                    almost_full;
    logic                    almost_empty;
    logic                    wr_ovf;
    logic                    rd_udf;

    modport master (
        output flush, wr_data, wr_en, rd_en,
        input  wr_vld, rd_data, rd_vld, level,
        input  almost_full, almost_empty, wr_ovf, rd_udf
    );

    modport slave (
        input  flush, wr_data, wr_en, rd_en,
        output wr_vld, rd_data, rd_vld, level,
        output almost_full, almost_empty, wr_ovf, rd_udf
    );
endinterface

// File: rtl/ipml_sync_prefetch_fifo_v2_0.sv
// Single-clock FWFT FIFO: SDP RAM feeding a 2-entry output stage,
// optional empty-FIFO bypass, level/threshold flags, flush, sticky misuse flags.
module ipml_sync_prefetch_fifo_v2_0 #(
    parameter int c_DEPTH_WIDTH = 4,
    parameter int c_DATA_WIDTH  = 32,
    parameter int c_BYPASS      = 0,
    parameter int c_AF_LEVEL    = 14,
    parameter int c_AE_LEVEL    = 2
) (
    input  logic clk,
    input  logic rst,
    ipml_sync_prefetch_fifo_v2_0_if.slave bus
);
    localparam int AW    = c_DEPTH_WIDTH;
    localparam int DW    = c_DATA_WIDTH;
    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] AF_LVL = (AW+1)'(c_AF_LEVEL);
    localparam logic [AW:0] AE_LVL = (AW+1)'(c_AE_LEVEL);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] ram_dout_q;

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic [AW:0]   level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic          ram_empty;
    logic          ram_full;
    logic          push;
    logic          pop;
    logic          byp;
    logic          push_ram;
    logic          issue;
    logic          in_vld;
    logic [DW-1:0] in_data;

    assign ram_empty = (wr_ptr_q == rd_ptr_q);
    assign ram_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign push = bus.wr_en & ~ram_full & ~bus.flush;
    assign pop  = bus.rd_en & (cnt_q != 2'd0) & ~bus.flush;

    // Bypass only when nothing older sits in RAM or in flight, so order holds.
    assign byp      = (c_BYPASS != 0) & ram_empty & ~pend_q & (cnt_q != 2'd2);
    assign push_ram = push & ~byp;

    assign issue = ~ram_empty & ~bus.flush &
                   ((cnt_q == 2'd0) | ((cnt_q == 2'd1) & ~pend_q) | pop);

    assign in_vld  = pend_q | (push & byp);
    assign in_data = pend_q ? ram_dout_q : bus.wr_data;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_ram);
        rd_ptr_d = rd_ptr_q + (AW+1)'(issue);
        pend_d   = issue;
        level_d  = level_q + (AW+1)'(push) - (AW+1)'(pop);
        ovf_d    = ovf_q | (bus.wr_en & ram_full);
        udf_d    = udf_q | (bus.rd_en & (cnt_q == 2'd0));
        head_d   = head_q;
        tail_d   = tail_q;
        cnt_d    = cnt_q;
        case ({pop, in_vld})
            2'b01: begin
                if (cnt_q == 2'd0) head_d = in_data;
                else               tail_d = in_data;
                cnt_d = cnt_q + 2'd1;
            end
            2'b10: begin
                if (cnt_q == 2'd2) head_d = tail_q;
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = in_data;
                end else begin
                    head_d = in_data;
                end
            end
            default: ;
        endcase
        // Flush drops everything, including a RAM word still in flight.
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            pend_d   = 1'b0;
            level_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
            cnt_d    = 2'd0;
            head_d   = head_q;
            tail_d   = tail_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            cnt_q    <= 2'd0;
            pend_q   <= 1'b0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ram) mem_q[wr_ptr_q[AW-1:0]] <= bus.wr_data;
        if (issue)    ram_dout_q <= mem_q[rd_ptr_q[AW-1:0]];
    end

    assign bus.wr_vld       = ~ram_full;
    assign bus.rd_vld       = (cnt_q != 2'd0);
    assign bus.rd_data      = head_q;
    assign bus.level        = level_q;
    assign bus.almost_full  = (level_q >= AF_LVL);
    assign bus.almost_empty = (level_q <= AE_LVL);
    assign bus.wr_ovf       = ovf_q;
    assign bus.rd_udf       = udf_q;
endmodule

// File: tb/tb_ipml_sync_prefetch_fifo_v2_0.sv
// Bench for the prefetch FIFO: a non-bypass and a bypass instance share
// one stimulus stream; each has its own queue model and monitor.
`timescale 1ns/1ps
module tb_ipml_sync_prefetch_fifo_v2_0;
    localparam int AW  = 4;
    localparam int DW  = 32;
    localparam int CAP = 18;
    localparam int AF  = 14;
    localparam int AE  = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    int            errors = 0;
    int            checks = 0;

    always #5 clk = ~clk;

    task automatic chk(input int d, input string n,
                       input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL dut%0d %s: got 0x%0h expected 0x%0h", d, n, a, e);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_d
        ipml_sync_prefetch_fifo_v2_0_if #(
            .c_DEPTH_WIDTH(AW), .c_DATA_WIDTH(DW)
        ) bus ();

        ipml_sync_prefetch_fifo_v2_0 #(
            .c_DEPTH_WIDTH(AW), .c_DATA_WIDTH(DW), .c_BYPASS(g),
            .c_AF_LEVEL(AF), .c_AE_LEVEL(AE)
        ) u_dut (
            .clk(clk), .rst(rst), .bus(bus)
        );

        assign bus.flush   = flush;
        assign bus.wr_en   = wr_en;
        assign bus.wr_data = wr_data;
        assign bus.rd_en   = rd_en;

        int            lvl = 0;
        int            stall = 0;
        logic          ovf = 1'b0;
        logic          udf = 1'b0;
        logic          hold = 1'b0;
        logic          acc = 1'b0;
        logic [DW-1:0] last = '0;
        logic [DW-1:0] q[$];

        // Monitor: compares outputs with the model and pops delivered words.
        always @(negedge clk) begin
            if (rst) begin
                lvl = 0; stall = 0; ovf = 1'b0; udf = 1'b0;
                hold = 1'b0; acc = 1'b0; last = '0;
            end else begin
                chk(g, "level", 64'(bus.level), 64'(lvl));
                chk(g, "almost_full", 64'(bus.almost_full), 64'(lvl >= AF));
                chk(g, "almost_empty", 64'(bus.almost_empty), 64'(lvl <= AE));
                chk(g, "wr_vld", 64'(bus.wr_vld), 64'(lvl < CAP));
                chk(g, "wr_ovf", 64'(bus.wr_ovf), 64'(ovf));
                chk(g, "rd_udf", 64'(bus.rd_udf), 64'(udf));
                if (hold) chk(g, "hold_vld", 64'(bus.rd_vld), 64'd1);
                if (bus.rd_vld) begin
                    if (q.size() == 0) chk(g, "vld_empty", 64'd1, 64'd0);
                    else begin
                        chk(g, "head", 64'(bus.rd_data), 64'(q[0]));
                        last = q[0];
                    end
                end else begin
                    chk(g, "rd_data_hold", 64'(bus.rd_data), 64'(last));
                end
                stall = (lvl > 0 && !bus.rd_vld) ? stall + 1 : 0;
                chk(g, "stall", 64'(stall > 3), 64'd0);
                acc = !flush && wr_en && lvl < CAP;
                if (flush) begin
                    lvl = 0; ovf = 1'b0; udf = 1'b0; hold = 1'b0;
                end else begin
                    if (wr_en && lvl >= CAP) ovf = 1'b1;
                    if (rd_en && !bus.rd_vld) udf = 1'b1;
                    hold = bus.rd_vld && !rd_en;
                    if (rd_en && bus.rd_vld && q.size() > 0) begin
                        void'(q.pop_front());
                        lvl--;
                    end
                    if (acc) lvl++;
                end
            end
        end

        // Scoreboard writer: records accepted words after the monitor ran.
        always @(negedge clk) begin
            #1;
            if (rst || flush) q.delete();
            else if (acc) q.push_back(wr_data);
        end
    end

    task automatic drive(input logic we, input logic [DW-1:0] wd,
                         input logic re, input logic fl);
        wr_en = we; wr_data = wd; rd_en = re; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_vals(input int d, input logic wv, input logic rv,
                            input logic [DW-1:0] rdd, input logic [AW:0] lv,
                            input logic af, input logic ae,
                            input logic ov, input logic ud);
        chk(d, "rst_wr_vld", 64'(wv), 64'd1);
        chk(d, "rst_rd_vld", 64'(rv), 64'd0);
        chk(d, "rst_rd_data", 64'(rdd), 64'd0);
        chk(d, "rst_level", 64'(lv), 64'd0);
        chk(d, "rst_afull", 64'(af), 64'd0);
        chk(d, "rst_aempty", 64'(ae), 64'd1);
        chk(d, "rst_ovf", 64'(ov), 64'd0);
        chk(d, "rst_udf", 64'(ud), 64'd0);
    endtask

    task automatic rst_both();
        rst_vals(0, g_d[0].bus.wr_vld, g_d[0].bus.rd_vld, g_d[0].bus.rd_data,
                 g_d[0].bus.level, g_d[0].bus.almost_full,
                 g_d[0].bus.almost_empty, g_d[0].bus.wr_ovf, g_d[0].bus.rd_udf);
        rst_vals(1, g_d[1].bus.wr_vld, g_d[1].bus.rd_vld, g_d[1].bus.rd_data,
                 g_d[1].bus.level, g_d[1].bus.almost_full,
                 g_d[1].bus.almost_empty, g_d[1].bus.wr_ovf, g_d[1].bus.rd_udf);
    endtask

    task automatic rnd(input int n, input int wp, input int rp, input int fp);
        for (int i = 0; i < n; i++) begin
            drive(logic'($urandom_range(0, 99) < wp), DW'($urandom),
                  logic'($urandom_range(0, 99) < rp),
                  logic'($urandom_range(0, 999) < fp));
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 60; i++) begin
            if (g_d[0].bus.level == 0 && g_d[1].bus.level == 0) break;
            drive(1'b0, '0, 1'b1, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        chk(0, "drain_done", 64'(g_d[0].bus.level), 64'd0);
        chk(1, "drain_done", 64'(g_d[1].bus.level), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_both();
        rst = 1'b0;

        // First-word latency: bypass at N+1, RAM path at N+3
        drive(1'b1, 32'h11, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        chk(1, "byp_vld", 64'(g_d[1].bus.rd_vld), 64'd1);
        chk(1, "byp_data", 64'(g_d[1].bus.rd_data), 64'h11);
        chk(0, "lat_c1", 64'(g_d[0].bus.rd_vld), 64'd0);
        tick();
        chk(0, "lat_c2", 64'(g_d[0].bus.rd_vld), 64'd0);
        tick();
        chk(0, "lat_c3_vld", 64'(g_d[0].bus.rd_vld), 64'd1);
        chk(0, "lat_c3_data", 64'(g_d[0].bus.rd_data), 64'h11);
        chk(0, "lat_level", 64'(g_d[0].bus.level), 64'd1);
        chk(0, "lat_aempty", 64'(g_d[0].bus.almost_empty), 64'd1);
        chk(0, "lat_afull", 64'(g_d[0].bus.almost_full), 64'd0);
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 32'hA5, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        chk(1, "byp_a5_vld", 64'(g_d[1].bus.rd_vld), 64'd1);
        chk(1, "byp_a5_data", 64'(g_d[1].bus.rd_data), 64'hA5);
        repeat (3) tick();
        drain();

        // Fill to capacity, then overflow
        for (int i = 0; i < CAP; i++) begin
            drive(1'b1, DW'(i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            chk(d, "full_level", 64'(d == 0 ? g_d[0].bus.level : g_d[1].bus.level), 64'd18);
            chk(d, "full_wr_vld", 64'(d == 0 ? g_d[0].bus.wr_vld : g_d[1].bus.wr_vld), 64'd0);
        end
        drive(1'b1, 32'hDEAD, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        chk(0, "ovf_set", 64'(g_d[0].bus.wr_ovf), 64'd1);
        chk(1, "ovf_set", 64'(g_d[1].bus.wr_ovf), 64'd1);
        chk(0, "ovf_level", 64'(g_d[0].bus.level), 64'd18);
        drain();

        // Flush with 10 words stored and a pop request
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, DW'(32'h100 + i), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        repeat (4) tick();
        drive(1'b1, 32'hBAD, 1'b1, 1'b1);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        chk(0, "fl_level", 64'(g_d[0].bus.level), 64'd0);
        chk(1, "fl_level", 64'(g_d[1].bus.level), 64'd0);
        chk(0, "fl_rd_vld", 64'(g_d[0].bus.rd_vld), 64'd0);
        chk(1, "fl_rd_vld", 64'(g_d[1].bus.rd_vld), 64'd0);
        chk(0, "fl_wr_vld", 64'(g_d[0].bus.wr_vld), 64'd1);
        chk(0, "fl_ovf", 64'(g_d[0].bus.wr_ovf), 64'd0);
        chk(0, "fl_rd_data", 64'(g_d[0].bus.rd_data), 64'h100);
        chk(1, "fl_rd_data", 64'(g_d[1].bus.rd_data), 64'h100);
        repeat (6) tick();

        // Underflow on empty
        drive(1'b0, '0, 1'b1, 1'b0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b0);
        chk(0, "udf_set", 64'(g_d[0].bus.rd_udf), 64'd1);
        chk(1, "udf_set", 64'(g_d[1].bus.rd_udf), 64'd1);
        chk(1, "udf_level", 64'(g_d[1].bus.level), 64'd0);

        // Random traffic: balanced, write-heavy, read-heavy
        rnd(300, 50, 50, 10);
        rnd(150, 80, 20, 0);
        rnd(150, 20, 80, 5);
        drain();

        // Asynchronous reset in the middle of a burst
        rnd(25, 70, 30, 0);
        drive(1'b1, 32'h5A5A, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        rst_both();
        drive(1'b0, '0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        rnd(100, 50, 50, 0);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
